lane_swap_engine: RTL and testbench

Parametrised successor to the two-register swap block. It accepts a vector of LANES words, each WIDTH bits wide, and applies one of four permutations: pass, pairwise swap, reverse, or rotate-by-N. Rotation is done iteratively, one lane per cycle. Input and output use valid/ready handshakes, so the block can sit between register stages in the datapath.

---
 rtl/lane_swap_pkg.sv | 15 +
 rtl/lane_swap_engine_permute.sv | 27 ++
 rtl/lane_swap_engine.sv | 85 ++++++++
 tb/tb_lane_swap_engine.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lane_swap_pkg.sv
// lane_swap_pkg: shared mode and state encodings for the lane swap engine
package lane_swap_pkg;
    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_SWAP = 2'b01,
        MODE_REV  = 2'b10,
        MODE_ROT  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ROT  = 2'b01,
        ST_FULL = 2'b10
    } state_e;
endpackage

// File: rtl/lane_swap_engine_permute.sv
// lane_permute: combinational lane permutation (pass, pairwise swap, reverse, single-lane rotate)
// Ports:
//   mode     - permutation to apply; MODE_ROT moves every lane one step toward lane 0
//   in_data  - LANES lanes of WIDTH bits, lane i at [i*WIDTH +: WIDTH]
//   out_data - permuted lanes
module lane_permute
    import lane_swap_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  mode_e                    mode,
    input  logic [LANES*WIDTH-1:0]   in_data,
    output logic [LANES*WIDTH-1:0]   out_data
);
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        // With odd LANES the unpaired top lane maps to itself
        localparam int SW = (g % 2 == 0) ? ((g + 1 < LANES) ? g + 1 : g) : g - 1;
        localparam int RV = LANES - 1 - g;
        localparam int RT = (g + 1) % LANES;
        assign out_data[g*WIDTH +: WIDTH] =
            (mode == MODE_SWAP) ? in_data[SW*WIDTH +: WIDTH] :
            (mode == MODE_REV)  ? in_data[RV*WIDTH +: WIDTH] :
            (mode == MODE_ROT)  ? in_data[RT*WIDTH +: WIDTH] :
                                  in_data[g*WIDTH +: WIDTH];
    end
endmodule

// File: rtl/lane_swap_engine.sv
// lane_swap_engine: valid/ready lane permutation engine with iterative rotate
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - input handshake; in_mode/in_amt/in_data latched on accept
//   out_valid/out_ready   - output handshake; out_data held stable while out_valid
//   busy                  - high while a rotation is stepping
//   done_cnt              - number of results handed off, wrapping
module lane_swap_engine
    import lane_swap_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int AMT_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [AMT_W-1:0]       in_amt,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   busy,
    output logic [CNT_W-1:0]       done_cnt
);
    state_e                 r_state;
    logic [LANES*WIDTH-1:0] r_data;
    logic [AMT_W-1:0]       r_rem;
    logic [CNT_W-1:0]       r_cnt;
    mode_e                  w_mode;
    mode_e                  w_perm_mode;
    logic [AMT_W-1:0]       w_amt;
    logic [LANES*WIDTH-1:0] w_perm_in;
    logic [LANES*WIDTH-1:0] w_perm;
    logic                   w_accept;
    logic                   w_rot;

    assign w_mode    = mode_e'(in_mode);
    assign w_amt     = AMT_W'(32'(in_amt) % LANES);
    // A rotate by a multiple of LANES is an identity and takes the single-cycle path
    assign w_rot     = (w_mode == MODE_ROT) && (w_amt != '0);
    assign in_ready  = rst_n & ((r_state == ST_IDLE) | ((r_state == ST_FULL) & out_ready));
    assign w_accept  = in_valid & in_ready;
    // Rotations load raw data on accept, then step through the permuter one lane per cycle
    assign w_perm_mode = (r_state == ST_ROT) ? MODE_ROT : ((w_mode == MODE_ROT) ? MODE_PASS : w_mode);
    assign w_perm_in   = (r_state == ST_ROT) ? r_data : in_data;

    lane_permute #(.WIDTH(WIDTH), .LANES(LANES)) u_perm (
        .mode     (w_perm_mode),
        .in_data  (w_perm_in),
        .out_data (w_perm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else begin
            if (out_valid && out_ready)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == ST_ROT) begin
                r_data <= w_perm;
                r_rem  <= r_rem - 1'b1;
                if (r_rem == AMT_W'(1))
                    r_state <= ST_FULL;
            end else if (w_accept) begin
                r_data  <= w_perm;
                r_rem   <= w_amt;
                r_state <= w_rot ? ST_ROT : ST_FULL;
            end else if (r_state == ST_FULL && out_ready) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign busy      = (r_state == ST_ROT);
    assign out_data  = r_data;
    assign done_cnt  = r_cnt;
endmodule

// File: tb/tb_lane_swap_engine.sv
// tb_lane_swap_engine: table-driven directed bench for lane_swap_engine
module tb_lane_swap_engine;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic [1:0]  in_mode = 0;
    logic [3:0]  in_amt = 0;
    logic [31:0] in_data = 0;
    logic        out_ready = 0;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_data;
    logic [15:0] done_cnt;
    logic        in_ready2, out_valid2, busy2;
    logic [31:0] out_data2;
    logic [1:0]  done_cnt2;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    lane_swap_engine #(.WIDTH(8), .LANES(4), .AMT_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_amt(in_amt), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done_cnt(done_cnt)
    );

    lane_swap_engine #(.WIDTH(8), .LANES(4), .AMT_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_mode(in_mode), .in_amt(in_amt), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .busy(busy2), .done_cnt(done_cnt2)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  amt;
        logic [31:0] data;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done_cnt", 32'(done_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1;
        exp_cnt = 0;
    endtask

    // Applies one word with output held back, measures latency and busy time, then hands off
    task automatic run_vec(input string name, input logic [1:0] m, input logic [3:0] a,
                           input logic [31:0] d, input logic [31:0] e, input int lat);
        int n, nb;
        @(negedge clk);
        chk({name, "_in_ready"}, 32'(in_ready), 1);
        in_valid = 1; in_mode = m; in_amt = a; in_data = d; out_ready = 0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        n = 1; nb = 0;
        while (!out_valid && n < 40) begin
            if (busy) nb++;
            if (in_ready) begin
                n_err++;
                $display("FAIL %s_ready_in_rot: got 1 expected 0", name);
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(lat));
        chk({name, "_busy_cycles"}, 32'(nb), 32'(lat - 1));
        chk({name, "_data"}, out_data, e);
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
        exp_cnt++;
        chk({name, "_done_cnt"}, 32'(done_cnt), 32'(exp_cnt));
        chk({name, "_drained"}, 32'(out_valid), 0);
    endtask

    initial begin
        tbl[0]  = '{2'b01, 4'd0,  32'h44332211, 32'h33441122, 1};
        tbl[1]  = '{2'b10, 4'd0,  32'h44332211, 32'h11223344, 1};
        tbl[2]  = '{2'b00, 4'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1};
        tbl[3]  = '{2'b11, 4'd1,  32'h44332211, 32'h11443322, 2};
        tbl[4]  = '{2'b11, 4'd2,  32'h44332211, 32'h22114433, 3};
        tbl[5]  = '{2'b11, 4'd5,  32'h44332211, 32'h11443322, 2};
        tbl[6]  = '{2'b11, 4'd4,  32'h44332211, 32'h44332211, 1};
        tbl[7]  = '{2'b11, 4'd3,  32'h44332211, 32'h33221144, 4};
        tbl[8]  = '{2'b11, 4'd15, 32'h44332211, 32'h33221144, 4};
        tbl[9]  = '{2'b01, 4'd0,  32'hA1B2C3D4, 32'hB2A1D4C3, 1};
        tbl[10] = '{2'b11, 4'd0,  32'hCAFEF00D, 32'hCAFEF00D, 1};

        do_reset();
        for (int i = 0; i < 11; i++)
            run_vec($sformatf("vec%0d", i), tbl[i].mode, tbl[i].amt, tbl[i].data, tbl[i].exp, tbl[i].lat);

        // Backpressure: result held for 5 cycles while the next word waits
        @(negedge clk);
        in_valid = 1; in_mode = 2'b00; in_data = 32'h01020304; out_ready = 0;
        @(posedge clk);
        @(negedge clk);
        in_mode = 2'b10; in_data = 32'h0A0B0C0D;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", out_data, 32'h01020304);
            chk("bp_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1;
        #1 chk("bp_ready_comb", 32'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        exp_cnt++;
        chk("bp_cnt_once", 32'(done_cnt), 32'(exp_cnt));
        chk("bp_next_valid", 32'(out_valid), 1);
        chk("bp_next_data", out_data, 32'h0D0C0B0A);
        @(posedge clk);
        @(negedge clk);
        exp_cnt++;
        chk("bp_cnt_second", 32'(done_cnt), 32'(exp_cnt));
        chk("bp_idle", 32'(out_valid), 0);
        out_ready = 0;

        // Streaming: 8 back-to-back PASS words from a clean count
        do_reset();
        @(negedge clk);
        out_ready = 1; in_valid = 1; in_mode = 2'b00; in_data = 32'h1000_0000;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_data", out_data, 32'h1000_0000 + 32'(k));
            if (k == 7) in_valid = 0;
            else in_data = 32'h1000_0000 + 32'(k + 1);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
        chk("stream_cnt", 32'(done_cnt), 8);
        chk("stream_cnt_w2", 32'(done_cnt2), 0);

        // Asynchronous reset during a rotation
        @(negedge clk);
        in_valid = 1; in_mode = 2'b11; in_amt = 4'd3; in_data = 32'h44332211;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_done_cnt", 32'(done_cnt), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst_n = 1;
        exp_cnt = 0;
        #1 chk("arst_release_ready", 32'(in_ready), 1);
        run_vec("after_rst", 2'b10, 4'd0, 32'h44332211, 32'h11223344, 1);

        // Counter wrap on the CNT_W=2 instance
        do_reset();
        for (int k = 0; k < 5; k++)
            run_vec("wrap", 2'b00, 4'd0, 32'h55AA_0000 + 32'(k), 32'h55AA_0000 + 32'(k), 1);
        chk("wrap_cnt_w2", 32'(done_cnt2), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
